// File: rtl/fx_alu_seq.sv
// Sequential signed Q(INT_W).(FRAC_W) ALU with iterative multiply/MAC and a persistent accumulator.
// Optional macro ALU_OVERFLOW_FLAG_EN adds the o_overflow saturation flag output.
module fx_alu_seq #(
  parameter int unsigned INT_W  = 3,
  parameter int unsigned FRAC_W = 5,
  parameter int unsigned INST_W = 3,
  localparam int unsigned DATA_W = INT_W + FRAC_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data_a,
  input  logic [DATA_W-1:0] i_data_b,
  input  logic [INST_W-1:0] i_inst,
  output logic              o_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
`ifdef ALU_OVERFLOW_FLAG_EN
  ,
  output logic              o_overflow
`endif
);

  localparam int unsigned PW    = 2 * DATA_W;
  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [PW:0] RND_HALF = (PW + 1)'(2 ** (FRAC_W - 1));

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [INST_W-1:0] OP_ADD  = INST_W'(0);
  localparam logic [INST_W-1:0] OP_SUB  = INST_W'(1);
  localparam logic [INST_W-1:0] OP_MUL  = INST_W'(2);
  localparam logic [INST_W-1:0] OP_MAC  = INST_W'(3);
  localparam logic [INST_W-1:0] OP_MAX  = INST_W'(4);
  localparam logic [INST_W-1:0] OP_RELU = INST_W'(5);
  localparam logic [INST_W-1:0] OP_MEAN = INST_W'(6);

  logic [1:0]        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] a_r, a_n, b_r, b_n, data_n;
  logic [INST_W-1:0] inst_r, inst_n;
  logic [PW-1:0]     prod, prod_n, acc, acc_n;
  logic              valid_n, ready_n;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic              ovf_n;
`endif

  // Clip a one-bit-wide-overflow sum back to DATA_W.
  function automatic logic [DATA_W-1:0] clip_w1(input logic [DATA_W:0] s);
    if (s[DATA_W] != s[DATA_W-1]) clip_w1 = {s[DATA_W], {(DATA_W-1){~s[DATA_W]}}};
    else                          clip_w1 = s[DATA_W-1:0];
  endfunction

  logic [DATA_W:0]        sum_ab, dif_ab;
  logic [PW-1:0]          a_ext, partial, prod_fin, acc_sat, rnd_in;
  logic [PW:0]            mac_sum, rnd_sum;
  logic signed [PW:0]     rnd;
  logic                   last, mac_ovf, rnd_fits;
  logic [DATA_W-1:0]      rnd_clip;

  assign sum_ab = {i_data_a[DATA_W-1], i_data_a} + {i_data_b[DATA_W-1], i_data_b};
  assign dif_ab = {i_data_a[DATA_W-1], i_data_a} - {i_data_b[DATA_W-1], i_data_b};

  // Shift-add multiply; the sign bit of b carries negative weight.
  assign last     = (cnt == CNT_W'(DATA_W - 1));
  assign a_ext    = {{DATA_W{a_r[DATA_W-1]}}, a_r};
  assign partial  = a_ext << cnt;
  assign prod_fin = !b_r[cnt] ? prod : (last ? prod - partial : prod + partial);

  assign mac_sum  = {acc[PW-1], acc} + {prod_fin[PW-1], prod_fin};
  assign mac_ovf  = mac_sum[PW] ^ mac_sum[PW-1];
  assign acc_sat  = mac_ovf ? {mac_sum[PW], {(PW-1){~mac_sum[PW]}}} : mac_sum[PW-1:0];

  // Round half-up, drop fraction, then saturate to DATA_W.
  assign rnd_in   = (inst_r == OP_MAC) ? acc_sat : prod_fin;
  assign rnd_sum  = {rnd_in[PW-1], rnd_in} + RND_HALF;
  assign rnd      = $signed(rnd_sum) >>> FRAC_W;
  assign rnd_fits = (rnd[PW:DATA_W-1] == '0) || (&rnd[PW:DATA_W-1]);
  assign rnd_clip = rnd_fits ? rnd[DATA_W-1:0] : {rnd[PW], {(DATA_W-1){~rnd[PW]}}};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      a_r     <= '0;
      b_r     <= '0;
      inst_r  <= '0;
      prod    <= '0;
      acc     <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ready <= 1'b1;
`ifdef ALU_OVERFLOW_FLAG_EN
      o_overflow <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      a_r     <= a_n;
      b_r     <= b_n;
      inst_r  <= inst_n;
      prod    <= prod_n;
      acc     <= acc_n;
      o_data  <= data_n;
      o_valid <= valid_n;
      o_ready <= ready_n;
`ifdef ALU_OVERFLOW_FLAG_EN
      o_overflow <= ovf_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    a_n     = a_r;
    b_n     = b_r;
    inst_n  = inst_r;
    prod_n  = prod;
    acc_n   = acc;
    data_n  = o_data;
`ifdef ALU_OVERFLOW_FLAG_EN
    ovf_n   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          a_n     = i_data_a;
          b_n     = i_data_b;
          inst_n  = i_inst;
          cnt_n   = '0;
          prod_n  = '0;
          state_n = S_OUT;
          case (i_inst)
            OP_ADD: begin
              data_n = clip_w1(sum_ab);
`ifdef ALU_OVERFLOW_FLAG_EN
              ovf_n  = sum_ab[DATA_W] ^ sum_ab[DATA_W-1];
`endif
            end
            OP_SUB: begin
              data_n = clip_w1(dif_ab);
`ifdef ALU_OVERFLOW_FLAG_EN
              ovf_n  = dif_ab[DATA_W] ^ dif_ab[DATA_W-1];
`endif
            end
            OP_MUL, OP_MAC: state_n = S_ITER;
            OP_MAX:  data_n = ($signed(i_data_a) > $signed(i_data_b)) ? i_data_a : i_data_b;
            OP_RELU: data_n = i_data_a[DATA_W-1] ? '0 : i_data_a;
            OP_MEAN: data_n = sum_ab[DATA_W:1];
            default: begin
              // CLR
              acc_n  = '0;
              data_n = '0;
            end
          endcase
        end
      end
      S_ITER: begin
        prod_n = prod_fin;
        cnt_n  = cnt + CNT_W'(1);
        if (last) begin
          state_n = S_OUT;
          cnt_n   = '0;
          data_n  = rnd_clip;
          if (inst_r == OP_MAC) acc_n = acc_sat;
`ifdef ALU_OVERFLOW_FLAG_EN
          ovf_n   = !rnd_fits || ((inst_r == OP_MAC) && mac_ovf);
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase
    valid_n = (state_n == S_OUT);
    ready_n = (state_n == S_IDLE);
  end

endmodule

// File: tb/tb_fx_alu_seq.sv
// Directed bench for fx_alu_seq: latency, arithmetic results, accumulator and reset behaviour.
module tb_fx_alu_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [7:0] a, b;
  logic [2:0] inst;
  logic       ready, ovalid;
  logic [7:0] data;
`ifdef ALU_OVERFLOW_FLAG_EN
  logic       ovf;
  logic       ovf_s;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, MAC = 3'd3;
  localparam logic [2:0] MAX = 3'd4, RELU = 3'd5, MEAN = 3'd6, CLR = 3'd7;

  fx_alu_seq dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_data_a(a),
    .i_data_b(b),
    .i_inst  (inst),
    .o_ready (ready),
    .o_valid (ovalid),
    .o_data  (data)
`ifdef ALU_OVERFLOW_FLAG_EN
    ,
    .o_overflow(ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Wait for ready, then present one request for exactly one rising edge.
  task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] ti);
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_wait: ready=%b required 1", ready);
    end
    valid = 1'b1; a = ta; b = tb_v; inst = ti;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  // Latency counted in negedges after the accept edge; -1 means no result seen.
  task automatic wait_valid(output int lat, output logic [7:0] d);
    lat = -1;
    d   = 8'hxx;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ovalid) begin
        lat = i;
        d   = data;
`ifdef ALU_OVERFLOW_FLAG_EN
        ovf_s = ovf;
`endif
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; a = '0; b = '0; inst = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", ready); end
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", ovalid); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", data); end
    rst = 1'b0;
  endtask

  task automatic test_add_sub();
    int lat; logic [7:0] d;
    issue(8'h30, 8'h50, ADD);
    wait_valid(lat, d);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_lat: got %0d required 1", lat); end
    checks++; if (d !== 8'h7F) begin errors++; $display("FAIL add_sat: got %h required 7f", d); end
`ifdef ALU_OVERFLOW_FLAG_EN
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL add_ovf: got %b required 1", ovf_s); end
`endif
    @(negedge clk);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL add_pulse: got %b required 0", ovalid); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b required 1", ready); end
    checks++; if (data !== 8'h7F) begin errors++; $display("FAIL add_hold: got %h required 7f", data); end
    issue(8'h80, 8'h20, SUB);
    wait_valid(lat, d);
    checks++; if (lat !== 1 || d !== 8'h80) begin errors++; $display("FAIL sub_sat: got lat=%0d d=%h required 1/80", lat, d); end
    issue(8'h10, 8'h08, ADD);
    wait_valid(lat, d);
    checks++; if (d !== 8'h18) begin errors++; $display("FAIL add_plain: got %h required 18", d); end
`ifdef ALU_OVERFLOW_FLAG_EN
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL add_noovf: got %b required 0", ovf_s); end
`endif
  endtask

  task automatic test_mul();
    int lat; logic [7:0] d;
    issue(8'h30, 8'h50, MUL);
    wait_valid(lat, d);
    checks++; if (lat !== 9) begin errors++; $display("FAIL mul_lat: got %0d required 9", lat); end
    checks++; if (d !== 8'h78) begin errors++; $display("FAIL mul_pos: got %h required 78", d); end
    @(negedge clk);
    checks++; if (ovalid !== 1'b0) begin errors++; $display("FAIL mul_pulse: got %b required 0", ovalid); end
    issue(8'hF0, 8'h01, MUL);
    wait_valid(lat, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL mul_round: got %h required 00", d); end
    issue(8'hE0, 8'h30, MUL);
    wait_valid(lat, d);
    checks++; if (d !== 8'hD0) begin errors++; $display("FAIL mul_neg: got %h required d0", d); end
    issue(8'h80, 8'h80, MUL);
    wait_valid(lat, d);
    checks++; if (d !== 8'h7F) begin errors++; $display("FAIL mul_sat: got %h required 7f", d); end
`ifdef ALU_OVERFLOW_FLAG_EN
    checks++; if (ovf_s !== 1'b1) begin errors++; $display("FAIL mul_ovf: got %b required 1", ovf_s); end
`endif
  endtask

  task automatic test_mac();
    int lat; logic [7:0] d;
    issue(8'h00, 8'h00, CLR);
    wait_valid(lat, d);
    checks++; if (lat !== 1 || d !== 8'h00) begin errors++; $display("FAIL clr0: got lat=%0d d=%h required 1/00", lat, d); end
    issue(8'h20, 8'h20, MAC);
    wait_valid(lat, d);
    checks++; if (lat !== 9 || d !== 8'h20) begin errors++; $display("FAIL mac1: got lat=%0d d=%h required 9/20", lat, d); end
    issue(8'h20, 8'h20, MAC);
    wait_valid(lat, d);
    checks++; if (d !== 8'h40) begin errors++; $display("FAIL mac2: got %h required 40", d); end
    issue(8'h00, 8'h00, CLR);
    wait_valid(lat, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL clr1: got %h required 00", d); end
    issue(8'h20, 8'h20, MAC);
    wait_valid(lat, d);
    checks++; if (d !== 8'h20) begin errors++; $display("FAIL mac3: got %h required 20", d); end
  endtask

  task automatic test_single_ops();
    int lat; logic [7:0] d;
    issue(8'h80, 8'h7F, MAX);
    wait_valid(lat, d);
    checks++; if (d !== 8'h7F) begin errors++; $display("FAIL max: got %h required 7f", d); end
`ifdef ALU_OVERFLOW_FLAG_EN
    checks++; if (ovf_s !== 1'b0) begin errors++; $display("FAIL max_ovf: got %b required 0", ovf_s); end
`endif
    issue(8'hE0, 8'h00, RELU);
    wait_valid(lat, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL relu_neg: got %h required 00", d); end
    issue(8'h30, 8'h00, RELU);
    wait_valid(lat, d);
    checks++; if (d !== 8'h30) begin errors++; $display("FAIL relu_pos: got %h required 30", d); end
    issue(8'h7F, 8'h7F, MEAN);
    wait_valid(lat, d);
    checks++; if (d !== 8'h7F) begin errors++; $display("FAIL mean_max: got %h required 7f", d); end
    issue(8'hFF, 8'h00, MEAN);
    wait_valid(lat, d);
    checks++; if (lat !== 1 || d !== 8'hFF) begin errors++; $display("FAIL mean_floor: got lat=%0d d=%h required 1/ff", lat, d); end
  endtask

  task automatic test_busy_ignore();
    int first_v, first_r, pulses;
    logic [7:0] d;
    first_v = -1; first_r = -1; pulses = 0; d = 8'hxx;
    issue(8'h30, 8'h50, MUL);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (ovalid) begin
        pulses++;
        if (first_v < 0) begin first_v = i; d = data; end
      end
      if (ready && first_r < 0) first_r = i;
      if (i == 3) begin valid = 1'b1; a = 8'h10; b = 8'h10; inst = ADD; end
      if (i == 4) valid = 1'b0;
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL busy_pulses: got %0d required 1", pulses); end
    checks++; if (first_v !== 9 || d !== 8'h78) begin errors++; $display("FAIL busy_result: got idx=%0d d=%h required 9/78", first_v, d); end
    checks++; if (first_r !== 10) begin errors++; $display("FAIL busy_ready: got %0d required 10", first_r); end
    checks++; if (data !== 8'h78) begin errors++; $display("FAIL busy_hold: got %h required 78", data); end
  endtask

  task automatic test_reset_mid_mac();
    int pulses, lat;
    logic [7:0] d;
    pulses = 0;
    issue(8'h20, 8'h20, MAC);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (ovalid) pulses++;
      if (i == 3) rst = 1'b1;
      if (i == 5) rst = 1'b0;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_valid: got %0d pulses required 0", pulses); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b required 1", ready); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL rst_mid_data: got %h required 00", data); end
    issue(8'h20, 8'h20, MAC);
    wait_valid(lat, d);
    checks++; if (lat !== 9 || d !== 8'h20) begin errors++; $display("FAIL rst_acc_clear: got lat=%0d d=%h required 9/20", lat, d); end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_mul();
    test_mac();
    test_single_ops();
    test_busy_ignore();
    test_reset_mid_mac();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
